// File: rtl/ball_mover_pkg.sv
// Shared types and screen constants for the ball mover slice and its neighbours
// (sync generator, renderer).
package ball_mover_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned COORD_W  = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_e;

endpackage

// File: rtl/ball_mover_if.sv
// Control inputs and registered sprite outputs between ball_mover and its neighbours.
interface ball_mover_if;

  logic                                 tick;
  logic                                 start;
  logic                                 pause;
  logic [ball_mover_pkg::COORD_W-1:0]   ballX;
  logic [ball_mover_pkg::COORD_W-1:0]   ballY;
  logic                                 dirX;
  logic                                 dirY;
  logic                                 bounce;
  logic                                 running;

  modport master (
    output tick, start, pause,
    input  ballX, ballY, dirX, dirY, bounce, running
  );

  modport slave (
    input  tick, start, pause,
    output ballX, ballY, dirX, dirY, bounce, running
  );

endinterface

// File: rtl/ball_mover_axis_stepper.sv
// One axis of ball motion: advances by SPEED, clamps to [0, limit] and flips
// direction on a wall hit.
module axis_stepper
#(
  parameter int unsigned SPEED = 2
) (
  input  logic [ball_mover_pkg::COORD_W-1:0] pos,
  input  logic                               dir,
  input  logic                               en,
  input  logic [ball_mover_pkg::COORD_W-1:0] limit,
  output logic [ball_mover_pkg::COORD_W-1:0] pos_nxt,
  output logic                               dir_nxt,
  output logic                               hit
);

  import ball_mover_pkg::*;

  // One extra bit on the rightward compare so pos + SPEED cannot wrap.
  always_comb begin
    pos_nxt = pos;
    dir_nxt = dir;
    hit     = 1'b0;
    if (en) begin
      if (dir) begin
        if (({1'b0, pos} + (COORD_W+1)'(SPEED)) >= {1'b0, limit}) begin
          pos_nxt = limit;
          dir_nxt = 1'b0;
          hit     = 1'b1;
        end else begin
          pos_nxt = pos + COORD_W'(SPEED);
        end
      end else begin
        if (pos <= COORD_W'(SPEED)) begin
          pos_nxt = '0;
          dir_nxt = 1'b1;
          hit     = 1'b1;
        end else begin
          pos_nxt = pos - COORD_W'(SPEED);
        end
      end
    end
  end

endmodule

// File: rtl/ball_mover.sv
// Frame-rate ball sprite mover: serve/run/pause FSM plus registered position,
// direction, bounce pulse and running flag.
module ball_mover
#(
  parameter int unsigned H_ACTIVE  = ball_mover_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE  = ball_mover_pkg::V_ACTIVE,
  parameter int unsigned BALL_SIZE = 8,
  parameter int unsigned SPEED     = 2,
  parameter int unsigned X_INIT    = 316,
  parameter int unsigned Y_INIT    = 236
) (
  input  logic         clk,
  input  logic         reset_n,
  ball_mover_if.slave  bus
);

  import ball_mover_pkg::*;

  localparam logic [COORD_W-1:0] XMAX = COORD_W'(H_ACTIVE - BALL_SIZE);
  localparam logic [COORD_W-1:0] YMAX = COORD_W'(V_ACTIVE - BALL_SIZE);

  state_e               state_q, state_d;
  logic [COORD_W-1:0]   ball_x_q, ball_x_d;
  logic [COORD_W-1:0]   ball_y_q, ball_y_d;
  logic                 dir_x_q, dir_x_d;
  logic                 dir_y_q, dir_y_d;
  logic                 bounce_q, bounce_d;
  logic                 running_q, running_d;

  logic [COORD_W-1:0]   x_nxt, y_nxt;
  logic                 x_dir_nxt, y_dir_nxt;
  logic                 x_hit, y_hit;
  logic                 step_en;

  // Motion uses the state before this edge, so the edge leaving IDLE or PAUSED never moves.
  assign step_en = (state_q == RUN) && !bus.pause && bus.tick;

  axis_stepper #(.SPEED(SPEED)) u_step_x (
    .pos     (ball_x_q),
    .dir     (dir_x_q),
    .en      (step_en),
    .limit   (XMAX),
    .pos_nxt (x_nxt),
    .dir_nxt (x_dir_nxt),
    .hit     (x_hit)
  );

  axis_stepper #(.SPEED(SPEED)) u_step_y (
    .pos     (ball_y_q),
    .dir     (dir_y_q),
    .en      (step_en),
    .limit   (YMAX),
    .pos_nxt (y_nxt),
    .dir_nxt (y_dir_nxt),
    .hit     (y_hit)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ball_x_q  <= COORD_W'(X_INIT);
      ball_y_q  <= COORD_W'(Y_INIT);
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b1;
      bounce_q  <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      bounce_q  <= bounce_d;
      running_q <= running_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start)  state_d = RUN;
      RUN:     if (bus.pause)  state_d = PAUSED;
      PAUSED:  if (!bus.pause) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ball_x_d  = x_nxt;
    ball_y_d  = y_nxt;
    dir_x_d   = x_dir_nxt;
    dir_y_d   = y_dir_nxt;
    bounce_d  = x_hit | y_hit;
    running_d = (state_d == RUN);
  end

  assign bus.ballX   = ball_x_q;
  assign bus.ballY   = ball_y_q;
  assign bus.dirX    = dir_x_q;
  assign bus.dirY    = dir_y_q;
  assign bus.bounce  = bounce_q;
  assign bus.running = running_q;

endmodule

// File: doc/ball_mover.md
Name: ball_mover

Overview:
- Consumes the single-cycle frame-rate enable from the clock divider (about 30 Hz) and advances a square ball sprite across the 640x480 active VGA area.
- Bounces the ball off all four screen edges.
- Presents registered top-left coordinates to the pixel renderer downstream.
- Runs a small control FSM that holds the ball at its serve position until started, and freezes it while paused.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- BALL_SIZE, 8, ball edge length in pixels.
- SPEED, 2, pixels moved per axis per tick (1..BALL_SIZE).
- X_INIT, 316, serve X (top-left).
- Y_INIT, 236, serve Y (top-left).

Ports:
- clk  input  1  system clock, 100 MHz.
- reset_n  input  1  synchronous, active-low reset.
- tick  input  1  one-cycle movement enable from the clock divider.
- start  input  1  level; launches the ball from IDLE.
- pause  input  1  level; freezes motion while high.
- ballX  output  10  ball top-left X, registered.
- ballY  output  10  ball top-left Y, registered.
- dirX  output  1  1 = moving right, 0 = left.
- dirY  output  1  1 = moving down, 0 = up.
- bounce  output  1  one-cycle pulse on any edge hit.
- running  output  1  high in the RUN state.

Behaviour:
- One clock, clk. Reset is synchronous and active-low (reset_n sampled on the posedge clk). All state changes occur on posedge clk.
- Reset values: state=IDLE, ballX=X_INIT, ballY=Y_INIT, dirX=1, dirY=1, bounce=0, running=0.
- Reset asserted mid-motion wins over every other input on that edge.
- FSM states are IDLE, RUN, PAUSED:
  - IDLE -> RUN when start=1.
  - RUN -> PAUSED when pause=1.
  - PAUSED -> RUN when pause=0.
  - There is no return to IDLE except by reset.
  - In IDLE, pause is ignored.
- Motion happens only when state==RUN, pause==0 and tick==1 on the same edge.
  - A tick on the edge that leaves IDLE does not move the ball.
  - A tick with pause=1 in RUN does not move the ball; the state goes to PAUSED.
- Per axis per qualifying tick, with XMAX = H_ACTIVE-BALL_SIZE (632) and YMAX = V_ACTIVE-BALL_SIZE (472):
  - Moving right: if ballX + SPEED >= XMAX, then ballX <= XMAX, dirX <= 0 and a hit is flagged. Otherwise ballX <= ballX + SPEED.
  - Moving left: if ballX <= SPEED, then ballX <= 0, dirX <= 1 and a hit is flagged. Otherwise ballX <= ballX - SPEED.
  - The Y axis follows the same rules against YMAX.
- Comparisons use 11-bit unsigned arithmetic, so no wrap-around is possible. Coordinates never leave [0, XMAX] and [0, YMAX].
- Overshoot is clamped to the wall, not reflected.
- bounce is 1 for exactly the cycle after the update edge if either axis hit.
  - A simultaneous corner hit flips both directions and gives a single pulse.
  - bounce is 0 at all other times.
- Latency: coordinates change on the same edge that samples tick. Outputs are stable between ticks.
- running = (state==RUN), registered.

Decomposition:
- Shared package or header holds:
  - the FSM state encodings (IDLE=2'd0, RUN=2'd1, PAUSED=2'd2);
  - the screen constants H_ACTIVE/V_ACTIVE, reused by the sync generator and renderer.
- One natural sub-module, axis_stepper, instantiated twice (X and Y):
  - inputs: position, direction, step enable, limit;
  - outputs: next position, next direction, hit.
- The top level holds the FSM and the output registers.

Test Plan:
- Reset, then 5 ticks with start=0 -> ballX=316, ballY=236, dirX=1, dirY=1, running=0, bounce never high.
- start=1 with tick on the same edge -> RUN, position still 316/236; next tick -> 318/238.
- From the serve position, 118 ticks -> ballY=472, dirY=0, bounce pulses once with ballX=552. After 40 more ticks -> ballX=632, dirX=0, second single bounce pulse.
- SPEED=3, X_INIT=316, Y_INIT=236:
  - after 105 ticks -> ballX=631;
  - tick 106 -> clamps to ballX=632, dirX=0, bounce=1.
- X_INIT=160, Y_INIT=0: after 236 ticks -> ballX=632, ballY=472, both directions flip, exactly one bounce cycle.
- pause=1 for 10 ticks in RUN -> coordinates frozen, running=0. pause=0 -> next tick resumes motion.
- reset_n=0 asserted mid-motion -> next edge restores 316/236, IDLE, directions 1/1.
